// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
   localparam int          CNT_W             = 4;

endpackage

// File: rtl/data_mem_array.sv
// Word array with a synchronous write port and a combinational read by index.
module data_mem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 64,
   parameter int IDX_W      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_W-1:0]      idx,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Handshaken data-memory responder: one access at a time, WAIT_CYCLES busy
// cycles, o_ready low while the pipeline must freeze.
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int          DATA_WIDTH  = 32,
   parameter int          DEPTH       = 64,
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          WAIT_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_mem_r_en,
   input  logic                  i_mem_w_en,
   input  logic [31:0]           i_address,
   input  logic [DATA_WIDTH-1:0] i_write_data,
   output logic [DATA_WIDTH-1:0] o_read_data,
   output logic                  o_ready
);

   localparam int IDX_W = $clog2(DEPTH);

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic                  op_w;
   logic [IDX_W-1:0]      idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   logic                  req;
   logic [31:0]           offset;
   logic [IDX_W-1:0]      idx_in;
   logic                  unused_offset_bits;
   logic                  complete_busy;
   logic                  complete_fast;
   logic                  arr_we;
   logic                  rd_load;
   logic [IDX_W-1:0]      arr_idx;
   logic [DATA_WIDTH-1:0] arr_wdata;
   logic [DATA_WIDTH-1:0] arr_rdata;

   assign req    = i_mem_r_en | i_mem_w_en;
   assign offset = i_address - BASE_ADDR;
   // Byte offset and bits above the index are dropped: addresses wrap by design.
   assign idx_in             = offset[IDX_W+1:2];
   assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0]};

   // With zero wait states the access completes straight out of IDLE,
   // so the array is driven from the live inputs instead of the latches.
   assign complete_busy = (state == BUSY) && (cnt == CNT_W'(1));
   assign complete_fast = (WAIT_CYCLES == 0) && (state == IDLE) && req;

   assign arr_idx   = complete_fast ? idx_in       : idx_q;
   assign arr_wdata = complete_fast ? i_write_data : wdata_q;
   assign arr_we    = !rst && ((complete_busy && op_w) || (complete_fast && i_mem_w_en));
   assign rd_load   = (complete_busy && !op_w) || (complete_fast && !i_mem_w_en);

   assign o_ready = (state == DONE) || ((state == IDLE) && !req);

   data_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .idx   (arr_idx),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         op_w        <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         o_read_data <= '0;
      end else begin
         if (rd_load) o_read_data <= arr_rdata;
         case (state)
            IDLE: begin
               if (req) begin
                  op_w    <= i_mem_w_en;
                  idx_q   <= idx_in;
                  wdata_q <= i_write_data;
                  cnt     <= CNT_W'(WAIT_CYCLES);
                  state   <= (WAIT_CYCLES == 0) ? DONE : BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with 3 wait states, one with 0.
module tb_data_mem_responder;

   logic        clk;
   logic        rst;
   logic        r_en  [2];
   logic        w_en  [2];
   logic [31:0] addr  [2];
   logic [31:0] wd    [2];
   logic [31:0] rdata [2];
   logic        rdy   [2];

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q [$];

   data_mem_responder #(.WAIT_CYCLES(3)) u_a (
      .clk(clk), .rst(rst), .i_mem_r_en(r_en[0]), .i_mem_w_en(w_en[0]),
      .i_address(addr[0]), .i_write_data(wd[0]), .o_read_data(rdata[0]), .o_ready(rdy[0])
   );

   data_mem_responder #(.WAIT_CYCLES(0)) u_b (
      .clk(clk), .rst(rst), .i_mem_r_en(r_en[1]), .i_mem_w_en(w_en[1]),
      .i_address(addr[1]), .i_write_data(wd[1]), .o_read_data(rdata[1]), .o_ready(rdy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          sel;
      bit          w;
      bit          r;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One access: request for a single cycle, count freeze cycles, compare in DONE.
   task automatic xact(input int s, input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp, input bit chg,
                       input logic [31:0] ca, input logic [31:0] cd, input string nm);
      int lat;
      int wc;
      logic [31:0] e;
      wc = (s == 0) ? 3 : 0;
      @(posedge clk); #1;
      w_en[s] = w; r_en[s] = r; addr[s] = a; wd[s] = d;
      exp_q.push_back(exp);
      lat = 0;
      @(negedge clk);
      while (!rdy[s] && lat <= 40) begin
         lat++;
         @(posedge clk); #1;
         w_en[s] = 1'b0; r_en[s] = 1'b0;
         if (chg) begin addr[s] = ca; wd[s] = cd; end
         @(negedge clk);
      end
      w_en[s] = 1'b0; r_en[s] = 1'b0;
      chk({nm, "_latency"}, 32'(lat), 32'(wc + 1));
      e = exp_q.pop_front();
      chk({nm, "_rdata"}, rdata[s], e);
      @(negedge clk);
      chk({nm, "_idle_ready"}, {31'd0, rdy[s]}, 32'd1);
      chk({nm, "_rdata_hold"}, rdata[s], e);
   endtask

   vec_t vecs [13];

   initial begin
      for (int i = 0; i < 2; i++) begin
         r_en[i] = 1'b0; w_en[i] = 1'b0; addr[i] = 32'd0; wd[i] = 32'd0;
      end
      rst = 1'b1;

      vecs[0]  = '{0, 1, 0, 32'd1024, 32'hDEADBEEF, 32'h0};
      vecs[1]  = '{0, 0, 1, 32'd1024, 32'h0,        32'hDEADBEEF};
      vecs[2]  = '{0, 1, 0, 32'd1028, 32'h11,       32'hDEADBEEF};
      vecs[3]  = '{0, 1, 0, 32'd1284, 32'h22,       32'hDEADBEEF};
      vecs[4]  = '{0, 0, 1, 32'd1028, 32'h0,        32'h22};
      vecs[5]  = '{0, 0, 1, 32'd1030, 32'h0,        32'h22};
      vecs[6]  = '{0, 1, 0, 32'd1020, 32'hA5A5A5A5, 32'h22};
      vecs[7]  = '{0, 0, 1, 32'd1276, 32'h0,        32'hA5A5A5A5};
      vecs[8]  = '{0, 1, 0, 32'd1036, 32'h66,       32'hA5A5A5A5};
      vecs[9]  = '{1, 1, 0, 32'd1040, 32'hCAFE0001, 32'h0};
      vecs[10] = '{1, 0, 1, 32'd1040, 32'h0,        32'hCAFE0001};
      vecs[11] = '{1, 1, 1, 32'd1044, 32'h12345678, 32'hCAFE0001};
      vecs[12] = '{1, 0, 1, 32'd1044, 32'h0,        32'h12345678};

      // Reset then idle
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("reset_idle_ready_a_%0d", c), {31'd0, rdy[0]}, 32'd1);
         chk($sformatf("reset_idle_ready_b_%0d", c), {31'd0, rdy[1]}, 32'd1);
      end
      chk("reset_rdata_a", rdata[0], 32'h0);
      chk("reset_rdata_b", rdata[1], 32'h0);

      for (int i = 0; i < 13; i++)
         xact(vecs[i].sel, vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].exp_rd,
              1'b0, 32'h0, 32'h0, $sformatf("vec%0d", i));

      // Inputs changed while BUSY must not affect the latched write
      xact(0, 1, 0, 32'd1032, 32'h77, 32'hA5A5A5A5, 1'b1, 32'd1036, 32'h99, "busy_change_wr");
      xact(0, 0, 1, 32'd1032, 32'h0, 32'h77, 1'b0, 32'h0, 32'h0, "busy_change_rd_orig");
      xact(0, 0, 1, 32'd1036, 32'h0, 32'h66, 1'b0, 32'h0, 32'h0, "busy_change_rd_other");

      // Reset in the commit cycle of a write discards it
      @(posedge clk); #1;
      w_en[0] = 1'b1; addr[0] = 32'd1028; wd[0] = 32'h55;
      @(posedge clk); #1;
      w_en[0] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready", {31'd0, rdy[0]}, 32'd1);
      chk("midrst_rdata", rdata[0], 32'h0);
      @(negedge clk);
      chk("midrst_still_idle", {31'd0, rdy[0]}, 32'd1);
      xact(0, 0, 1, 32'd1028, 32'h0, 32'h22, 1'b0, 32'h0, 32'h0, "midrst_rd");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
